// File: rtl/niosduino_pio_pkg.sv
// Shared constants for the NIOSDuino parallel I/O ports: register map,
// edge-select and interrupt-source encodings, plus the per-bit edge detector.
package niosduino_pio_pkg;

    localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
    localparam logic [2:0] PIO_ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] PIO_ADDR_EDGECAP = 3'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    localparam int unsigned IRQ_LEVEL = 0;
    localparam int unsigned IRQ_EDGE  = 1;

    function automatic logic [31:0] pio_edge_detect(input logic [31:0] cur,
                                                    input logic [31:0] prev,
                                                    input int unsigned edge_type);
        logic [31:0] hit;
        hit = '0;
        case (edge_type)
            EDGE_RISING:  hit = cur & ~prev;
            EDGE_FALLING: hit = ~cur & prev;
            default:      hit = cur ^ prev;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/niosduino_pio_sync.sv
// Multi-stage synchroniser bringing an asynchronous input bus into the clk domain.
module niosduino_pio_sync #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/niosduino_core_pio_in.sv
// Avalon-MM parallel input port: synchronised DATA, per-bit edge capture (W1C)
// and a maskable level- or edge-sourced interrupt.
module niosduino_core_pio_in
    import niosduino_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned IRQ_TYPE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic             wr_stb;
    logic             rd_stb;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] ecap_clr;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edgecap_nxt;
    logic [WIDTH-1:0] irqmask;
    logic [31:0]      rd_mux;
    logic [31:0]      sync_ext;
    logic [31:0]      sync_d_ext;
    logic [31:0]      edge_ext;

    assign wr_stb = chipselect && !write_n;
    assign rd_stb = chipselect && !read_n;
    assign wdata  = writedata[WIDTH-1:0];

    niosduino_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (in_port),
        .dout  (sync)
    );

    always_comb begin
        sync_ext               = '0;
        sync_d_ext             = '0;
        sync_ext[WIDTH-1:0]    = sync;
        sync_d_ext[WIDTH-1:0]  = sync_d;
        edge_ext               = pio_edge_detect(sync_ext, sync_d_ext, EDGE_TYPE);
        edge_hit               = edge_ext[WIDTH-1:0];
    end

    // Set has priority over a same-cycle clear: OR the new edges in last.
    always_comb begin
        ecap_clr    = (wr_stb && address == PIO_ADDR_EDGECAP) ? wdata : '0;
        edgecap_nxt = (edgecap & ~ecap_clr) | edge_hit;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = sync;
            PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
            default:          rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_d   <= '0;
            edgecap  <= '0;
            irqmask  <= '0;
            readdata <= '0;
        end else begin
            sync_d  <= sync;
            edgecap <= edgecap_nxt;
            if (wr_stb && address == PIO_ADDR_IRQMASK) begin
                irqmask <= wdata;
            end
            if (rd_stb) begin
                readdata <= rd_mux;
            end
        end
    end

    generate
        if (IRQ_TYPE == IRQ_EDGE) begin : g_irq_edge
            assign irq = |(edgecap & irqmask);
        end else begin : g_irq_level
            assign irq = |(sync & irqmask);
        end
    endgenerate

endmodule

// File: tb/tb_niosduino_core_pio_in.sv
// Self-checking bench: three differently configured ports on one shared bus,
// checked each cycle against a history-based model plus directed literals.
module tb_niosduino_core_pio_in;

    localparam int NI = 3;
    localparam int WP [NI] = '{32, 8, 4};
    localparam int SP [NI] = '{2, 3, 4};
    localparam int EP [NI] = '{0, 1, 2};
    localparam int IP [NI] = '{1, 0, 1};
    localparam int HLEN = 4096;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_port;
    logic [31:0] rdata [NI];
    logic        irqs  [NI];

    int checks;
    int errors;

    niosduino_core_pio_in #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rdata[0]), .in_port(in_port), .irq(irqs[0]));

    niosduino_core_pio_in #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(1), .IRQ_TYPE(0)) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rdata[1]), .in_port(in_port[7:0]), .irq(irqs[1]));

    niosduino_core_pio_in #(.WIDTH(4), .SYNC_STAGES(4), .EDGE_TYPE(2), .IRQ_TYPE(1)) u_dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rdata[2]), .in_port(in_port[3:0]), .irq(irqs[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pin samples indexed by clock count since reset.
    logic [31:0] samp [HLEN];
    int          m_cyc;
    logic [31:0] m_ecap [NI];
    logic [31:0] m_mask [NI];
    logic [31:0] m_rd   [NI];

    function automatic logic [31:0] wm(input int i);
        if (WP[i] >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << WP[i]) - 32'd1;
    endfunction

    // Synchronised value after clock c: the pin value sampled S-1 clocks earlier.
    function automatic logic [31:0] sync_at(input int i, input int c);
        int k;
        k = c - SP[i] + 1;
        if (k < 1) return 32'd0;
        return samp[k % HLEN] & wm(i);
    endfunction

    function automatic logic [31:0] edges(input int i, input logic [31:0] cur,
                                          input logic [31:0] prev);
        case (EP[i])
            0:       return cur & ~prev;
            1:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc = 0;
            for (int i = 0; i < NI; i++) begin
                m_ecap[i] = '0;
                m_mask[i] = '0;
                m_rd[i]   = '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                logic [31:0] s_now;
                logic [31:0] clr;
                s_now = sync_at(i, m_cyc);
                if (chipselect && !read_n) begin
                    case (address)
                        3'd0:    m_rd[i] = s_now;
                        3'd2:    m_rd[i] = m_mask[i];
                        3'd3:    m_rd[i] = m_ecap[i];
                        default: m_rd[i] = '0;
                    endcase
                end
                clr = (chipselect && !write_n && address == 3'd3) ? (writedata & wm(i)) : '0;
                m_ecap[i] = (m_ecap[i] & ~clr) | edges(i, s_now, sync_at(i, m_cyc - 1));
                if (chipselect && !write_n && address == 3'd2) m_mask[i] = writedata & wm(i);
            end
            m_cyc = m_cyc + 1;
            samp[m_cyc % HLEN] = in_port;
        end
    end

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h want %h at %0t", name, i, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic exp_irq;
            exp_irq = (IP[i] == 1) ? |(m_ecap[i] & m_mask[i])
                                   : |(sync_at(i, m_cyc) & m_mask[i]);
            chk("model_readdata", i, rdata[i], m_rd[i]);
            chk("model_irq", i, {31'd0, irqs[i]}, {31'd0, exp_irq});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        tick(1);
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic chk3(input string name, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2);
        chk(name, 0, rdata[0], e0);
        chk(name, 1, rdata[1], e1);
        chk(name, 2, rdata[2], e2);
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = '0; writedata = '0; in_port = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk3("reset_readdata", 0, 0, 0);
        for (int i = 0; i < NI; i++) chk("reset_irq", i, {31'd0, irqs[i]}, 32'd0);

        rd(3'd3); chk3("idle_edgecap", 0, 0, 0);
        rd(3'd2); chk3("idle_irqmask", 0, 0, 0);
        for (int a = 1; a < 8; a++) begin
            if (a != 2 && a != 3) begin
                rd(3'(a)); chk3("idle_unmapped", 0, 0, 0);
            end
        end
        tick(2);
        rd(3'd0); chk3("idle_data", 32'hFFFF_FFFF, 32'hFF, 32'hF);

        // Rising capture and W1C on the 32-bit rising/edge-irq port.
        in_port = 32'h0; tick(6); wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd2, 32'h4);
        chk("irq_before_edge", 0, {31'd0, irqs[0]}, 32'd0);
        in_port = 32'h5; tick(2);
        chk("irq_at_sync", 0, {31'd0, irqs[0]}, 32'd0);
        tick(1);
        chk("irq_at_capture", 0, {31'd0, irqs[0]}, 32'd1);
        rd(3'd3); chk("rise_edgecap", 0, rdata[0], 32'h5);
        wr(3'd3, 32'h4);
        chk("irq_after_w1c", 0, {31'd0, irqs[0]}, 32'd0);
        rd(3'd3); chk("w1c_edgecap", 0, rdata[0], 32'h1);

        // Clear of bit 0 lands on the same clock as its new rising edge.
        in_port = 32'h0; tick(6); wr(3'd3, 32'hFFFF_FFFF);
        in_port = 32'h5; tick(2); wr(3'd3, 32'h1);
        rd(3'd3); chk("collision_edgecap", 0, rdata[0], 32'h5);

        // Bit 3 falls then rises: rising / falling / any ports differ.
        in_port = 32'h8; tick(8); wr(3'd3, 32'hFFFF_FFFF);
        in_port = 32'h0; tick(6);
        rd(3'd3); chk3("fall_edgecap", 32'h0, 32'h8, 32'h8);
        wr(3'd3, 32'hFFFF_FFFF);
        in_port = 32'h8; tick(8);
        rd(3'd3); chk3("rerise_edgecap", 32'h8, 32'h0, 32'h8);

        // Level interrupt on the 8-bit port.
        wr(3'd2, 32'h2);
        in_port = 32'hA; tick(2);
        chk("level_irq_early", 1, {31'd0, irqs[1]}, 32'd0);
        tick(1);
        chk("level_irq_high", 1, {31'd0, irqs[1]}, 32'd1);
        wr(3'd0, 32'h0);
        chk("level_irq_data_wr", 1, {31'd0, irqs[1]}, 32'd1);
        rd(3'd0); chk("data_after_wr", 1, rdata[1], 32'hA);
        tick(5);
        in_port = 32'h8; tick(2);
        chk("level_irq_hold", 1, {31'd0, irqs[1]}, 32'd1);
        tick(1);
        chk("level_irq_low", 1, {31'd0, irqs[1]}, 32'd0);

        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2); chk3("mask_width", 32'hFFFF_FFFF, 32'hFF, 32'hF);

        // Asynchronous reset mid-cycle, no clock edge needed.
        reset = 1'b1;
        #1;
        chk3("async_reset_rd", 0, 0, 0);
        for (int i = 0; i < NI; i++) chk("async_reset_irq", i, {31'd0, irqs[i]}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        tick(1);
        rd(3'd3); chk3("post_reset_edgecap", 0, 0, 0);

        for (int n = 0; n < 4000; n++) begin
            chipselect = ($urandom_range(0, 3) != 0);
            read_n     = $urandom_range(0, 1) == 1;
            write_n    = $urandom_range(0, 2) != 0;
            case ($urandom_range(0, 3))
                0:       address = 3'd2;
                1:       address = 3'd3;
                2:       address = 3'd0;
                default: address = 3'($urandom_range(0, 7));
            endcase
            case ($urandom_range(0, 2))
                0:       writedata = 32'hFFFF_FFFF;
                1:       writedata = 32'd1 << $urandom_range(0, 31);
                default: writedata = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) in_port = $urandom;
            reset = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        reset = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        tick(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
